// File: rtl/ram_strobe_responder_pkg.sv
// Shared definitions for the strobe-interface memory responder.
// Holds the transfer width codes (same numbering as the existing width
// macros), the responder state encoding and the byte-lane helper functions
// used for alignment, byte enables and read-data masking.
package ram_strobe_responder_pkg;

  localparam logic [1:0] RAM_WIDTH8  = 2'd0;
  localparam logic [1:0] RAM_WIDTH16 = 2'd1;
  localparam logic [1:0] RAM_WIDTH32 = 2'd2;
  localparam logic [1:0] RAM_WIDTH64 = 2'd3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_e;

  // A misaligned byte lane is rounded down to the natural boundary of the
  // transfer width, so misaligned requests are served aligned rather than
  // flagged as errors.
  function automatic logic [2:0] alignLane(input logic [1:0] width,
                                           input logic [2:0] lane);
    logic [2:0] aligned;
    case (width)
      RAM_WIDTH8:  aligned = lane;
      RAM_WIDTH16: aligned = {lane[2:1], 1'b0};
      RAM_WIDTH32: aligned = {lane[2], 2'b00};
      default:     aligned = 3'b000;
    endcase
    return aligned;
  endfunction

  // Byte enable for one 64-bit word: a run of 1/2/4/8 ones placed at the
  // aligned lane.
  function automatic logic [7:0] laneMask(input logic [1:0] width,
                                          input logic [2:0] lane);
    logic [7:0] base;
    case (width)
      RAM_WIDTH8:  base = 8'h01;
      RAM_WIDTH16: base = 8'h03;
      RAM_WIDTH32: base = 8'h0F;
      default:     base = 8'hFF;
    endcase
    return base << alignLane(width, lane);
  endfunction

  // Keeps only the right-justified bits of a transfer of the given width.
  function automatic logic [63:0] widthDataMask(input logic [1:0] width);
    logic [63:0] mask;
    case (width)
      RAM_WIDTH8:  mask = 64'h0000_0000_0000_00FF;
      RAM_WIDTH16: mask = 64'h0000_0000_0000_FFFF;
      RAM_WIDTH32: mask = 64'h0000_0000_FFFF_FFFF;
      default:     mask = 64'hFFFF_FFFF_FFFF_FFFF;
    endcase
    return mask;
  endfunction

endpackage

// File: rtl/ram_lane_array.sv
// 2^DEPTH_LOG2 x 64-bit storage array for the strobe responder.
// Ports:
//   clk_i    - clock
//   we_i     - write enable
//   be_i     - per-byte write enable (bit n covers bits 8n+7:8n)
//   waddr_i  - write word index
//   wdata_i  - write data, already placed in its byte lanes
//   raddr_i  - read word index
//   rdata_o  - registered read data (word at raddr_i from the previous edge)
// Contents are never reset so the array maps onto block RAM.
module ram_lane_array #(
  parameter int DEPTH_LOG2 = 10
) (
  input  logic                  clk_i,
  input  logic                  we_i,
  input  logic [7:0]            be_i,
  input  logic [DEPTH_LOG2-1:0] waddr_i,
  input  logic [63:0]           wdata_i,
  input  logic [DEPTH_LOG2-1:0] raddr_i,
  output logic [63:0]           rdata_o
);

  logic [63:0] mem [2**DEPTH_LOG2];

  // Byte-enabled write plus read-first registered read, the shape BRAM
  // inference templates expect.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int b = 0; b < 8; b++) begin
        if (be_i[b]) begin
          mem[waddr_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
        end
      end
    end
    rdata_o <= mem[raddr_i];
  end

endmodule

// File: rtl/ram_strobe_responder.sv
// Responder end of the 64-bit strobe memory interface. Stands in for the
// DDR2 controller: accepts one read or write at a time, waits a fixed
// latency, then serves it from an internal 64-bit-wide array with byte-lane
// handling for 8/16/32/64-bit transfers.
// Ports:
//   clk_cpu, rst_n        - clock, asynchronous active-low reset
//   addr, width, data_in  - request fields, sampled on accept
//   rstrobe, wstrobe      - one-cycle read / write request pulses
//   data_out              - last read result, right-justified, zero-extended
//   transaction_complete  - one-cycle completion pulse
//   ready                 - high when a request can be accepted
//   protocol_err          - sticky, set by strobes that cannot be honoured
//   rd_count, wr_count    - wrapping counts of completed reads / writes
module ram_strobe_responder
  import ram_strobe_responder_pkg::*;
#(
  parameter int ADDR_W     = 28,
  parameter int DEPTH_LOG2 = 10,
  parameter int RD_LAT     = 4,
  parameter int WR_LAT     = 2
) (
  input  logic              clk_cpu,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] addr,
  input  logic [1:0]        width,
  input  logic [63:0]       data_in,
  input  logic              rstrobe,
  input  logic              wstrobe,
  output logic [63:0]       data_out,
  output logic              transaction_complete,
  output logic              ready,
  output logic              protocol_err,
  output logic [15:0]       rd_count,
  output logic [15:0]       wr_count
);

  // Latencies up to 256 cycles fit the 8-bit counter.
  localparam logic [7:0] RD_LOAD = 8'(RD_LAT - 1);
  localparam logic [7:0] WR_LOAD = 8'(WR_LAT - 1);

  state_e                state_q, state_d;
  logic [7:0]            latCnt_q, latCnt_d;
  logic                  opWrite_q, opWrite_d;
  logic [DEPTH_LOG2-1:0] wordIdx_q, wordIdx_d;
  logic [2:0]            lane_q, lane_d;
  logic [1:0]            width_q, width_d;
  logic [63:0]           wdata_q, wdata_d;
  logic [63:0]           dataOut_q, dataOut_d;
  logic                  protoErr_q, protoErr_d;
  logic [15:0]           rdCount_q, rdCount_d;
  logic [15:0]           wrCount_q, wrCount_d;

  logic                  errSet;
  logic                  finishing;
  logic [7:0]            byteEn;
  logic [63:0]           writeAligned;
  logic [63:0]           arrayRdata;
  logic [63:0]           readShifted;
  logic [DEPTH_LOG2-1:0] readIdx;
  logic                  addrUnused;

  // Address bits above the array depth are ignored so the array wraps.
  assign addrUnused = ^addr[ADDR_W-1:3+DEPTH_LOG2];

  // The edge that moves WAIT into DONE commits writes and captures reads.
  assign finishing    = (state_q == WAIT) && (latCnt_q == 8'd0);
  assign byteEn       = laneMask(width_q, lane_q);
  assign writeAligned = wdata_q << {lane_q, 3'b000};
  assign readShifted  = (arrayRdata >> {lane_q, 3'b000}) & widthDataMask(width_q);

  // The array read is registered, so the word index is presented straight
  // from the request in IDLE; the word is then valid by the finishing edge
  // even for a latency of one. That registered read is also why a latency of
  // one still passes through a single WAIT cycle: the pulse lands one cycle
  // after the accept edge, like every other latency.
  assign readIdx = (state_q == IDLE) ? addr[3 +: DEPTH_LOG2] : wordIdx_q;

  ram_lane_array #(
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_array (
    .clk_i   (clk_cpu),
    .we_i    (finishing & opWrite_q),
    .be_i    (byteEn),
    .waddr_i (wordIdx_q),
    .wdata_i (writeAligned),
    .raddr_i (readIdx),
    .rdata_o (arrayRdata)
  );

  // Next-state logic: accept in IDLE (write wins over a simultaneous read),
  // count down in WAIT, pulse for one cycle in DONE. Strobes arriving while
  // busy are dropped and only raise the sticky error.
  always_comb begin
    state_d   = state_q;
    latCnt_d  = latCnt_q;
    opWrite_d = opWrite_q;
    wordIdx_d = wordIdx_q;
    lane_d    = lane_q;
    width_d   = width_q;
    wdata_d   = wdata_q;
    errSet    = 1'b0;

    case (state_q)
      IDLE: begin
        if (rstrobe || wstrobe) begin
          opWrite_d = wstrobe;
          wordIdx_d = addr[3 +: DEPTH_LOG2];
          lane_d    = alignLane(width, addr[2:0]);
          width_d   = width;
          wdata_d   = data_in;
          latCnt_d  = wstrobe ? WR_LOAD : RD_LOAD;
          state_d   = WAIT;
          errSet    = rstrobe && wstrobe;
        end
      end
      WAIT: begin
        errSet = rstrobe || wstrobe;
        if (latCnt_q == 8'd0) begin
          state_d = DONE;
        end else begin
          latCnt_d = latCnt_q - 8'd1;
        end
      end
      DONE: begin
        errSet  = rstrobe || wstrobe;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    protoErr_d = protoErr_q | errSet;
    dataOut_d  = (finishing && !opWrite_q) ? readShifted : dataOut_q;
    rdCount_d  = (finishing && !opWrite_q) ? rdCount_q + 16'd1 : rdCount_q;
    wrCount_d  = (finishing && opWrite_q)  ? wrCount_q + 16'd1 : wrCount_q;
  end

  always_ff @(posedge clk_cpu or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      latCnt_q   <= 8'd0;
      opWrite_q  <= 1'b0;
      wordIdx_q  <= '0;
      lane_q     <= 3'd0;
      width_q    <= 2'd0;
      wdata_q    <= 64'd0;
      dataOut_q  <= 64'd0;
      protoErr_q <= 1'b0;
      rdCount_q  <= 16'd0;
      wrCount_q  <= 16'd0;
    end else begin
      state_q    <= state_d;
      latCnt_q   <= latCnt_d;
      opWrite_q  <= opWrite_d;
      wordIdx_q  <= wordIdx_d;
      lane_q     <= lane_d;
      width_q    <= width_d;
      wdata_q    <= wdata_d;
      dataOut_q  <= dataOut_d;
      protoErr_q <= protoErr_d;
      rdCount_q  <= rdCount_d;
      wrCount_q  <= wrCount_d;
    end
  end

  assign ready                = (state_q == IDLE);
  assign transaction_complete = (state_q == DONE);
  assign data_out             = dataOut_q;
  assign protocol_err         = protoErr_q;
  assign rd_count             = rdCount_q;
  assign wr_count             = wrCount_q;

endmodule

// File: tb/tb_ram_strobe_responder.sv
// Directed bench for ram_strobe_responder: a table of read/write vectors
// with hand-computed results, followed by hand-written sequences for
// protocol errors, reset during a transaction and a back-to-back line.
module tb_ram_strobe_responder;

  localparam int RD_LAT = 4;
  localparam int WR_LAT = 2;

  logic        clk_cpu = 1'b0;
  logic        rst_n;
  logic [27:0] addr;
  logic [1:0]  width;
  logic [63:0] data_in;
  logic        rstrobe;
  logic        wstrobe;
  logic [63:0] data_out;
  logic        transaction_complete;
  logic        ready;
  logic        protocol_err;
  logic [15:0] rd_count;
  logic [15:0] wr_count;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        isWrite;
    logic [27:0] addr;
    logic [1:0]  width;
    logic [63:0] data;
    logic [63:0] expData;
  } vec_t;

  vec_t vecs[13];

  ram_strobe_responder #(
    .ADDR_W(28), .DEPTH_LOG2(10), .RD_LAT(RD_LAT), .WR_LAT(WR_LAT)
  ) dut (
    .clk_cpu              (clk_cpu),
    .rst_n                (rst_n),
    .addr                 (addr),
    .width                (width),
    .data_in              (data_in),
    .rstrobe              (rstrobe),
    .wstrobe              (wstrobe),
    .data_out             (data_out),
    .transaction_complete (transaction_complete),
    .ready                (ready),
    .protocol_err         (protocol_err),
    .rd_count             (rd_count),
    .wr_count             (wr_count)
  );

  always #5 clk_cpu = ~clk_cpu;

  function automatic logic [63:0] lineWord(input int k);
    return {32'hA000_0000 + 32'(k), 32'h0000_5000 + 32'(k * 3)};
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act,
                             input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Called at a negedge. Waits for ready, issues the strobes for one cycle,
  // then samples every negedge until ready returns. injectK >= 0 raises
  // rstrobe at that negedge after the accept edge for one cycle.
  task automatic applyStimulus(input logic doRead, input logic doWrite,
                               input logic [27:0] a, input logic [1:0] w,
                               input logic [63:0] d, input int injectK,
                               output int pulseK, output int lowCnt,
                               output int pulses);
    int guard;
    guard = 0;
    while (!ready && guard < 40) begin
      @(negedge clk_cpu);
      guard++;
    end
    if (!ready) checkOutput("ready_wait_timeout", 64'd0, 64'd1);
    addr    = a;
    width   = w;
    data_in = d;
    rstrobe = doRead;
    wstrobe = doWrite;
    @(posedge clk_cpu);
    #1;
    rstrobe = 1'b0;
    wstrobe = 1'b0;
    pulseK = -1;
    lowCnt = 0;
    pulses = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk_cpu);
      rstrobe = (k == injectK);
      if (!ready) lowCnt++;
      if (transaction_complete) begin
        pulses++;
        if (pulseK < 0) pulseK = k;
      end
      if (ready && k > 0) break;
    end
    rstrobe = 1'b0;
    if (!ready) checkOutput("txn_timeout", 64'd0, 64'd1);
  endtask

  initial begin
    int pk, lc, np, lat, pulseSeen;

    rst_n   = 1'b0;
    addr    = '0;
    width   = 2'd0;
    data_in = '0;
    rstrobe = 1'b0;
    wstrobe = 1'b0;

    vecs[0]  = '{1'b1, 28'h40,   2'd3, 64'h0123456789ABCDEF, 64'h0};
    vecs[1]  = '{1'b0, 28'h40,   2'd3, 64'h0, 64'h0123456789ABCDEF};
    vecs[2]  = '{1'b1, 28'h80,   2'd3, 64'h0, 64'h0123456789ABCDEF};
    vecs[3]  = '{1'b1, 28'h83,   2'd0, 64'h55555555555555AA, 64'h0123456789ABCDEF};
    vecs[4]  = '{1'b1, 28'h86,   2'd1, 64'h123400000000BEEF, 64'h0123456789ABCDEF};
    vecs[5]  = '{1'b0, 28'h80,   2'd3, 64'h0, 64'hBEEF0000AA000000};
    vecs[6]  = '{1'b0, 28'h83,   2'd0, 64'h0, 64'h00000000000000AA};
    vecs[7]  = '{1'b1, 28'h13,   2'd2, 64'hFFFFFFFFCAFEF00D, 64'h00000000000000AA};
    vecs[8]  = '{1'b0, 28'h10,   2'd2, 64'h0, 64'h00000000CAFEF00D};
    vecs[9]  = '{1'b0, 28'h2010, 2'd2, 64'h0, 64'h00000000CAFEF00D};
    vecs[10] = '{1'b0, 28'h86,   2'd1, 64'h0, 64'h000000000000BEEF};
    vecs[11] = '{1'b0, 28'h85,   2'd2, 64'h0, 64'h00000000BEEF0000};
    vecs[12] = '{1'b0, 28'h41,   2'd1, 64'h0, 64'h000000000000CDEF};

    @(negedge clk_cpu);
    @(negedge clk_cpu);
    checkOutput("rst_data_out", data_out, 64'd0);
    checkOutput("rst_complete", 64'(transaction_complete), 64'd0);
    checkOutput("rst_ready", 64'(ready), 64'd1);
    checkOutput("rst_err", 64'(protocol_err), 64'd0);
    checkOutput("rst_rd_count", 64'(rd_count), 64'd0);
    checkOutput("rst_wr_count", 64'(wr_count), 64'd0);
    rst_n = 1'b1;
    @(negedge clk_cpu);
    checkOutput("idle_ready", 64'(ready), 64'd1);

    // Table-driven round trips, byte lanes, alignment and wrap.
    for (int i = 0; i < 13; i++) begin
      applyStimulus(!vecs[i].isWrite, vecs[i].isWrite, vecs[i].addr,
                    vecs[i].width, vecs[i].data, -1, pk, lc, np);
      lat = vecs[i].isWrite ? WR_LAT : RD_LAT;
      checkOutput($sformatf("vec%0d_latency", i), 64'(pk), 64'(lat));
      checkOutput($sformatf("vec%0d_ready_low", i), 64'(lc), 64'(lat + 1));
      checkOutput($sformatf("vec%0d_pulses", i), 64'(np), 64'd1);
      checkOutput($sformatf("vec%0d_data_out", i), data_out, vecs[i].expData);
    end
    checkOutput("table_wr_count", 64'(wr_count), 64'd5);
    checkOutput("table_rd_count", 64'(rd_count), 64'd8);
    checkOutput("table_err", 64'(protocol_err), 64'd0);

    // Read strobe during WAIT of a write is dropped and flagged.
    applyStimulus(1'b0, 1'b1, 28'h200, 2'd3, 64'h1122334455667788, 1, pk, lc, np);
    checkOutput("busy_strobe_latency", 64'(pk), 64'(WR_LAT));
    checkOutput("busy_strobe_pulses", 64'(np), 64'd1);
    checkOutput("busy_strobe_err", 64'(protocol_err), 64'd1);
    applyStimulus(1'b1, 1'b0, 28'h200, 2'd3, 64'h0, -1, pk, lc, np);
    checkOutput("busy_strobe_readback", data_out, 64'h1122334455667788);
    checkOutput("busy_strobe_wr_count", 64'(wr_count), 64'd6);
    checkOutput("busy_strobe_rd_count", 64'(rd_count), 64'd9);

    // Reset during WAIT aborts the write.
    applyStimulus(1'b0, 1'b1, 28'h100, 2'd3, 64'h11, -1, pk, lc, np);
    addr    = 28'h100;
    width   = 2'd3;
    data_in = 64'hDEADBEEFDEADBEEF;
    wstrobe = 1'b1;
    @(posedge clk_cpu);
    #1;
    wstrobe = 1'b0;
    @(negedge clk_cpu);
    checkOutput("abort_busy_before_reset", 64'(ready), 64'd0);
    rst_n = 1'b0;
    #1;
    checkOutput("abort_data_out", data_out, 64'd0);
    checkOutput("abort_complete", 64'(transaction_complete), 64'd0);
    checkOutput("abort_ready", 64'(ready), 64'd1);
    checkOutput("abort_err", 64'(protocol_err), 64'd0);
    checkOutput("abort_rd_count", 64'(rd_count), 64'd0);
    checkOutput("abort_wr_count", 64'(wr_count), 64'd0);
    @(negedge clk_cpu);
    rst_n = 1'b1;
    pulseSeen = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk_cpu);
      if (transaction_complete) pulseSeen++;
    end
    checkOutput("abort_no_pulse", 64'(pulseSeen), 64'd0);
    applyStimulus(1'b1, 1'b0, 28'h100, 2'd3, 64'h0, -1, pk, lc, np);
    checkOutput("abort_old_value", data_out, 64'h11);
    checkOutput("abort_rd_after", 64'(rd_count), 64'd1);

    // Simultaneous strobes: write wins, error flagged.
    applyStimulus(1'b1, 1'b1, 28'h300, 2'd3, 64'h5A5A5A5A5A5A5A5A, -1, pk, lc, np);
    checkOutput("dual_latency", 64'(pk), 64'(WR_LAT));
    checkOutput("dual_err", 64'(protocol_err), 64'd1);
    checkOutput("dual_wr_count", 64'(wr_count), 64'd1);
    checkOutput("dual_rd_count", 64'(rd_count), 64'd1);
    checkOutput("dual_data_held", data_out, 64'h11);
    applyStimulus(1'b1, 1'b0, 28'h300, 2'd3, 64'h0, -1, pk, lc, np);
    checkOutput("dual_readback", data_out, 64'h5A5A5A5A5A5A5A5A);

    // Back-to-back line of eight writes then eight reads.
    rst_n = 1'b0;
    @(negedge clk_cpu);
    rst_n = 1'b1;
    @(negedge clk_cpu);
    for (int k = 0; k < 8; k++) begin
      applyStimulus(1'b0, 1'b1, 28'h1000 + 28'(8 * k), 2'd3, lineWord(k), -1, pk, lc, np);
      checkOutput($sformatf("line_w%0d_ready_low", k), 64'(lc), 64'(WR_LAT + 1));
    end
    for (int k = 0; k < 8; k++) begin
      applyStimulus(1'b1, 1'b0, 28'h1000 + 28'(8 * k), 2'd3, 64'h0, -1, pk, lc, np);
      checkOutput($sformatf("line_r%0d_ready_low", k), 64'(lc), 64'(RD_LAT + 1));
      checkOutput($sformatf("line_r%0d_data", k), data_out, lineWord(k));
    end
    checkOutput("line_wr_count", 64'(wr_count), 64'd8);
    checkOutput("line_rd_count", 64'(rd_count), 64'd8);
    checkOutput("line_err", 64'(protocol_err), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
